sprite_renderer: RTL
====================

Name: sprite_renderer

Overview:
- Scanline-driven renderer that reads an 8-bit-wide, 16-row sprite bitmap ROM (e.g. the car bitmap) one row per scanline and serialises it into a 1-bit pixel stream.
- Each row is drawn mirrored to 16 pixels wide.
- Sits between the sprite bitmap ROM and the video mixer.
- The game/position logic supplies vstart, load and hstart strobes derived from the sync generator and the sprite X/Y compare.

Parameters:
- HEIGHT, 16, number of sprite rows drawn per frame (1..16).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- vstart  in  1  one-cycle strobe: sprite's first scanline begins; restarts row counting.
- load  in  1  one-cycle strobe during horizontal blanking: fetch the current row from the ROM.
- hstart  in  1  one-cycle strobe: sprite's first pixel column reached on this line.
- rom_addr  out  4  row address to the bitmap ROM.
- rom_bits  in  8  row data from the bitmap ROM (combinational ROM, valid the cycle after rom_addr changes).
- gfx  out  1  sprite pixel; 1 = opaque.
- in_progress  out  1  high while a frame of the sprite is being drawn.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset has priority over all inputs.
- Reset values: state=WAIT_VSTART, ycount=0, xcount=0, outbits=0, rom_addr=0, gfx=0, in_progress=0.
- Internal registers: state (3 bits), ycount (4 bits), xcount (4 bits), outbits (8 bits), rom_addr (4 bits, registered).
- WAIT_VSTART: ycount<=0; on vstart, go to WAIT_LOAD.
- WAIT_LOAD: xcount<=0; on load, go to LOAD_SETUP.
- LOAD_SETUP: rom_addr<=ycount; go to LOAD_FETCH.
- LOAD_FETCH: outbits<=rom_bits; go to WAIT_HSTART.
  - Fetch latency is 2 cycles from load; load-to-hstart spacing of at least 3 cycles is guaranteed by the caller.
- WAIT_HSTART: on hstart, go to DRAW.
- DRAW: xcount<=xcount+1 each cycle.
  - When xcount==15: ycount<=ycount+1.
  - Then if ycount==HEIGHT-1, go to WAIT_VSTART; else go to WAIT_LOAD.
- Pixel mapping (gfx is combinational from registered state):
  - Outside DRAW, gfx=0.
  - In DRAW with xcount=k: gfx=outbits[k] for k<8, and gfx=outbits[15-k] for k>=8.
  - Resulting order: bits 0..7, then bits 7..0.
- Pixel timing: hstart sampled in cycle N gives pixel k on gfx in cycle N+1+k, k=0..15. Exactly 16 pixel cycles per line.
- in_progress = (state != WAIT_VSTART), combinational.
- vstart in any state other than WAIT_VSTART (resync):
  - ycount<=0, xcount<=0, state<=WAIT_LOAD; any line in progress is aborted.
  - gfx is 0 from the next cycle.
  - Priority order: reset > vstart > normal transitions.
- load or hstart outside their waiting state: ignored (no state change, no counter change).
- Multiple strobes: hstart in the same cycle as load in WAIT_LOAD is ignored; only load acts.
- ycount wrap: with HEIGHT=16, ycount wraps 15->0 on the last line's end. State is already WAIT_VSTART, so no further rows are drawn until the next vstart.
- rom_addr holds its last value between fetches.

Test Plan:
- Reset then idle: assert reset 2 cycles, release -> gfx=0, in_progress=0, rom_addr=0, and all remain so with no strobes for 100 cycles.
- Single line: ROM row0=8'b00000001.
  - Stimulus: vstart, load 2 cycles later, hstart 5 cycles after load.
  - Required: rom_addr=0, and gfx pattern 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 in cycles N+1..N+16.
  - Required: in_progress=1, state returns to WAIT_LOAD.
- Full frame: ROM = car bitmap rows (row10=8'hFF, row0=row15=0), 16 load/hstart pairs.
  - Required: rom_addr sequences 0..15; row10 gives 16 consecutive 1s; rows 0 and 15 give all 0s.
  - Required: in_progress drops the cycle after the 16th line's last pixel.
- HEIGHT=4 build: after 4 lines -> in_progress=0; a further load/hstart produces no gfx and no rom_addr change.
- Mid-line vstart: vstart at pixel k=5 of line 3 -> gfx=0 from the next cycle.
  - Required: the next load fetches rom_addr=0.
- Spurious strobes:
  - hstart in WAIT_LOAD -> no gfx.
  - load during DRAW -> pixel stream unchanged, xcount unaffected.
  - reset asserted mid-DRAW -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_renderer
//  Summary  : Fetches one 8-bit sprite row per scanline from a bitmap ROM and
//             serialises it as a 16-pixel mirrored 1-bit pixel stream.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_renderer #(
   parameter int HEIGHT = 16                      // sprite rows per frame, 1..16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       vstart_i,
   input  logic       load_i,
   input  logic       hstart_i,
   output logic [3:0] rom_addr_o,
   input  logic [7:0] rom_bits_i,
   output logic       gfx_o,
   output logic       in_progress_o
);

   // Row index at which a frame is finished.
   localparam logic [3:0] c_last_row = 4'(HEIGHT - 1);

   typedef enum logic [2:0] {
      S_WAIT_VSTART = 3'd0,
      S_WAIT_LOAD   = 3'd1,
      S_LOAD_SETUP  = 3'd2,
      S_LOAD_FETCH  = 3'd3,
      S_WAIT_HSTART = 3'd4,
      S_DRAW        = 3'd5
   } state_t;

   state_t     state_q,    state_d;
   logic [3:0] ycount_q,   ycount_d;
   logic [3:0] xcount_q,   xcount_d;
   logic [7:0] outbits_q,  outbits_d;
   logic [3:0] rom_addr_q, rom_addr_d;

   // State and datapath registers; reset overrides every strobe.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_WAIT_VSTART;
         ycount_q   <= 4'd0;
         xcount_q   <= 4'd0;
         outbits_q  <= 8'd0;
         rom_addr_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         ycount_q   <= ycount_d;
         xcount_q   <= xcount_d;
         outbits_q  <= outbits_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   // Next-state logic: vstart resynchronises from any state, otherwise the
   // sequencer walks vstart -> (load -> fetch -> hstart -> 16 pixels) per row.
   always_comb begin
      state_d    = state_q;
      ycount_d   = ycount_q;
      xcount_d   = xcount_q;
      outbits_d  = outbits_q;
      rom_addr_d = rom_addr_q;

      if (vstart_i) begin
         ycount_d = 4'd0;
         xcount_d = 4'd0;
         state_d  = S_WAIT_LOAD;
      end else begin
         case (state_q)
            S_WAIT_VSTART: begin
               ycount_d = 4'd0;
            end
            S_WAIT_LOAD: begin
               xcount_d = 4'd0;
               if (load_i) begin
                  state_d = S_LOAD_SETUP;
               end
            end
            S_LOAD_SETUP: begin
               rom_addr_d = ycount_q;
               state_d    = S_LOAD_FETCH;
            end
            S_LOAD_FETCH: begin
               // ROM output is valid now, one cycle after the address moved.
               outbits_d = rom_bits_i;
               state_d   = S_WAIT_HSTART;
            end
            S_WAIT_HSTART: begin
               if (hstart_i) begin
                  state_d = S_DRAW;
               end
            end
            S_DRAW: begin
               xcount_d = xcount_q + 4'd1;
               if (xcount_q == 4'd15) begin
                  ycount_d = ycount_q + 4'd1;
                  state_d  = (ycount_q == c_last_row) ? S_WAIT_VSTART : S_WAIT_LOAD;
               end
            end
            default: begin
               state_d = S_WAIT_VSTART;
            end
         endcase
      end
   end

   // Pixel select: columns 0..7 take bits 0..7, columns 8..15 take bits 7..0,
   // so the low three index bits are inverted on the mirrored half.
   always_comb begin
      gfx_o = 1'b0;
      if (state_q == S_DRAW) begin
         gfx_o = xcount_q[3] ? outbits_q[~xcount_q[2:0]] : outbits_q[xcount_q[2:0]];
      end
   end

   assign in_progress_o = (state_q != S_WAIT_VSTART);
   assign rom_addr_o    = rom_addr_q;

endmodule
`default_nettype wire
